// File: rtl/mcpu_rom_sched_pkg.sv
// Shared types and constants for the program-ROM scheduler.
// Holds the FSM state encoding and the encryption key identifiers.
package mcpu_rom_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_AUX_RD = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] KEY_NONE      = 8'd0;
  localparam logic [7:0] KEY_TRIPOOL_A = 8'd1;
  localparam logic [7:0] KEY_TRIPOOL_B = 8'd2;

endpackage

// File: rtl/mcpu_rom_sched_if.sv
// Bus bundle between the CPU/aux requesters, the key config port and the SDRAM ROM port.
// The master side is the surrounding system; the slave side is the scheduler.
interface mcpu_rom_sched_if;
  logic        cfg_we;
  logic [7:0]  cfg_key;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic        aux_req;
  logic [15:0] aux_addr;
  logic        aux_ack;
  logic [7:0]  aux_dout;
  logic        rom_cs;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic        timeout_err;

  modport master (
    output cfg_we, cfg_key, cpu_req, cpu_addr, aux_req, aux_addr, rom_data, rom_valid,
    input  cpu_ack, cpu_dout, aux_ack, aux_dout, rom_cs, rom_addr, timeout_err
  );

  modport slave (
    input  cfg_we, cfg_key, cpu_req, cpu_addr, aux_req, aux_addr, rom_data, rom_valid,
    output cpu_ack, cpu_dout, aux_ack, aux_dout, rom_cs, rom_addr, timeout_err
  );
endinterface

// File: rtl/mcpu_rom_sched_decrypt.sv
// Combinational main-CPU byte decryption: Tri-Pool keys permute the middle six bits
// and swap/invert the outer two depending on address bits 13 and 2.
module mcpu_rom_sched_decrypt
  import mcpu_rom_sched_pkg::*;
(
  input  logic [7:0] i_key,
  input  logic [7:0] i_data,
  input  logic       i_a13,
  input  logic       i_a2,
  output logic [7:0] o_data
);

  logic w_tripool;
  assign w_tripool = (i_key == KEY_TRIPOOL_A) || (i_key == KEY_TRIPOOL_B);

  always_comb begin
    o_data = i_data;
    if (w_tripool) begin
      o_data[6:1] = {i_data[2], i_data[5], i_data[1], i_data[3], i_data[6], i_data[4]};
      if (!i_a13) begin
        o_data[7] = ~i_data[7];
        o_data[0] = ~i_data[0];
      end else if (!i_a2) begin
        o_data[7] = ~i_data[0];
        o_data[0] = ~i_data[7];
      end else begin
        o_data[7] = i_data[0];
        o_data[0] = i_data[7];
      end
    end
  end

endmodule

// File: rtl/mcpu_rom_sched.sv
// Arbitrates program-ROM reads between the main CPU and an auxiliary reader,
// decrypting CPU-bound bytes with the key latched at grant time.
module mcpu_rom_sched
  import mcpu_rom_sched_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter int AUX_STARVE = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  mcpu_rom_sched_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(AUX_STARVE + 1);

  state_t      r_state;
  logic [7:0]  r_key;
  logic [7:0]  r_key_q;
  logic        r_a13;
  logic        r_a2;
  logic [TW-1:0] r_tmo;
  logic [SW-1:0] r_starve;
  logic        r_cpu_served;
  logic        r_aux_served;
  logic        r_rom_cs;
  logic [15:0] r_rom_addr;
  logic        r_cpu_ack;
  logic        r_aux_ack;
  logic [7:0]  r_cpu_dout;
  logic [7:0]  r_aux_dout;
  logic        r_timeout_err;

  logic        w_cpu_elig;
  logic        w_aux_elig;
  logic        w_pick_aux;
  logic        w_tmo_hit;
  logic [7:0]  w_rd_byte;
  logic [7:0]  w_dec;

  assign w_cpu_elig = bus.cpu_req & ~r_cpu_served;
  assign w_aux_elig = bus.aux_req & ~r_aux_served;
  // Aux only jumps the queue once the CPU has had its run of consecutive grants.
  assign w_pick_aux = w_aux_elig & (~w_cpu_elig | (r_starve == SW'(AUX_STARVE)));
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
  assign w_rd_byte  = bus.rom_valid ? bus.rom_data : 8'hFF;

  mcpu_rom_sched_decrypt u_decrypt (
    .i_key  (r_key_q),
    .i_data (w_rd_byte),
    .i_a13  (r_a13),
    .i_a2   (r_a2),
    .o_data (w_dec)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_key         <= KEY_NONE;
      r_key_q       <= KEY_NONE;
      r_a13         <= 1'b0;
      r_a2          <= 1'b0;
      r_tmo         <= '0;
      r_starve      <= '0;
      r_cpu_served  <= 1'b0;
      r_aux_served  <= 1'b0;
      r_rom_cs      <= 1'b0;
      r_rom_addr    <= 16'h0000;
      r_cpu_ack     <= 1'b0;
      r_aux_ack     <= 1'b0;
      r_cpu_dout    <= 8'h00;
      r_aux_dout    <= 8'h00;
      r_timeout_err <= 1'b0;
    end else begin
      if (bus.cfg_we) r_key <= bus.cfg_key;
      // Served is set by the ack and dropped whenever the level request goes away.
      r_cpu_served <= bus.cpu_req & (r_cpu_served | r_cpu_ack);
      r_aux_served <= bus.aux_req & (r_aux_served | r_aux_ack);
      r_cpu_ack    <= 1'b0;
      r_aux_ack    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_aux_elig || w_pick_aux) begin
            r_starve <= '0;
          end else if (w_cpu_elig && (r_starve != SW'(AUX_STARVE))) begin
            r_starve <= r_starve + 1'b1;
          end
          if (w_cpu_elig || w_aux_elig) begin
            r_rom_addr <= w_pick_aux ? bus.aux_addr : bus.cpu_addr;
            r_key_q    <= r_key;
            r_a13      <= bus.cpu_addr[13];
            r_a2       <= bus.cpu_addr[2];
            r_rom_cs   <= 1'b1;
            r_tmo      <= '0;
            r_state    <= w_pick_aux ? ST_AUX_RD : ST_CPU_RD;
          end
        end
        ST_CPU_RD, ST_AUX_RD: begin
          if (bus.rom_valid || w_tmo_hit) begin
            r_rom_cs <= 1'b0;
            if (!bus.rom_valid) r_timeout_err <= 1'b1;
            if (r_state == ST_CPU_RD) begin
              r_cpu_ack  <= 1'b1;
              r_cpu_dout <= w_dec;
            end else begin
              r_aux_ack  <= 1'b1;
              r_aux_dout <= w_rd_byte;
            end
            r_state <= ST_RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_cs      = r_rom_cs;
  assign bus.rom_addr    = r_rom_addr;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.cpu_dout    = r_cpu_dout;
  assign bus.aux_ack     = r_aux_ack;
  assign bus.aux_dout    = r_aux_dout;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mcpu_rom_sched.sv
// Directed bench for mcpu_rom_sched: vector table of single reads plus hand sequences
// for arbitration fairness, timeout, mid-flight key change, held request and reset abort.
module tb_mcpu_rom_sched;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;

  // ROM responder knobs
  bit         rom_en   = 1'b1;
  int         rom_lat  = 0;
  logic [7:0] rom_byte = 8'h00;
  int         cs_cnt   = 0;
  int         last_cs_len = 0;
  logic [15:0] last_addr = 16'h0000;

  mcpu_rom_sched_if bus ();

  mcpu_rom_sched #(.TIMEOUT(8), .AUX_STARVE(4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    if (bus.rom_cs) begin
      bus.rom_valid = rom_en && (cs_cnt == rom_lat);
      last_addr = bus.rom_addr;
      cs_cnt++;
    end else begin
      bus.rom_valid = 1'b0;
      if (cs_cnt != 0) last_cs_len = cs_cnt;
      cs_cnt = 0;
    end
    bus.rom_data = rom_byte;
  end

  typedef struct {
    bit          aux;
    logic [7:0]  key;
    logic [15:0] addr;
    logic [7:0]  data;
    int          lat_l;
    logic [7:0]  exp_dout;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_key(input logic [7:0] k);
    bus.cfg_we = 1'b1;
    bus.cfg_key = k;
    @(negedge clk_sys);
    bus.cfg_we = 1'b0;
  endtask

  // Called at a negedge; that cycle is cycle 0 of the request.
  task automatic do_read(input bit aux, input logic [15:0] addr,
                         output logic [7:0] dout, output int lat);
    int t0;
    bit got;
    got = 1'b0;
    lat = -1;
    dout = 8'hxx;
    if (aux) begin bus.aux_req = 1'b1; bus.aux_addr = addr; end
    else     begin bus.cpu_req = 1'b1; bus.cpu_addr = addr; end
    t0 = cyc;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_sys);
      if (aux ? bus.aux_ack : bus.cpu_ack) begin
        got = 1'b1;
        lat = cyc - t0;
        dout = aux ? bus.aux_dout : bus.cpu_dout;
      end
    end
    bus.cpu_req = 1'b0;
    bus.aux_req = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_wait: got=no ack expected=ack within 400 cycles (addr %h)", addr);
    end
    @(negedge clk_sys);
  endtask

  initial begin
    logic [7:0] d;
    int         lat;
    int         ord[10];
    int         exp_ord[10];
    int         n;
    int         cs_seen;
    int         ack_seen;

    vecs[0]  = '{0, 8'd1, 16'h0000, 8'h04, 0, 8'hC1, 2};
    vecs[1]  = '{0, 8'd1, 16'h2000, 8'h04, 0, 8'hC1, 2};
    vecs[2]  = '{0, 8'd1, 16'h2004, 8'h04, 0, 8'h40, 2};
    vecs[3]  = '{0, 8'd0, 16'h1234, 8'h5A, 3, 8'h5A, 5};
    vecs[4]  = '{1, 8'd1, 16'h0000, 8'h04, 0, 8'h04, 2};
    vecs[5]  = '{0, 8'd1, 16'h0000, 8'hA5, 1, 8'h60, 3};
    vecs[6]  = '{0, 8'd2, 16'h2004, 8'hA5, 0, 8'hE1, 2};
    vecs[7]  = '{0, 8'd2, 16'h2000, 8'hA5, 0, 8'h60, 2};
    vecs[8]  = '{0, 8'd3, 16'h2004, 8'hA5, 0, 8'hA5, 2};
    vecs[9]  = '{1, 8'd2, 16'h2004, 8'hA5, 2, 8'hA5, 4};
    vecs[10] = '{0, 8'd0, 16'h0100, 8'h33, 7, 8'h33, 9};
    exp_ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    bus.cfg_we = 1'b0; bus.cfg_key = 8'h00;
    bus.cpu_req = 1'b0; bus.cpu_addr = 16'h0000;
    bus.aux_req = 1'b0; bus.aux_addr = 16'h0000;

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_aux_ack", 32'(bus.aux_ack), 32'd0);
    chk("rst_cpu_dout", 32'(bus.cpu_dout), 32'h00);
    chk("rst_aux_dout", 32'(bus.aux_dout), 32'h00);
    chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    @(negedge clk_sys);

    // Table-driven single reads
    for (int i = 0; i < 11; i++) begin
      set_key(vecs[i].key);
      rom_en = 1'b1;
      rom_lat = vecs[i].lat_l;
      rom_byte = vecs[i].data;
      do_read(vecs[i].aux, vecs[i].addr, d, lat);
      $display("vec %0d: aux=%0d key=%0d addr=%h data=%h L=%0d -> dout=%h lat=%0d",
               i, vecs[i].aux, vecs[i].key, vecs[i].addr, vecs[i].data, vecs[i].lat_l, d, lat);
      chk($sformatf("vec%0d_dout", i), 32'(d), 32'(vecs[i].exp_dout));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vecs[i].addr));
    end
    chk("valid_on_timeout_no_err", 32'(bus.timeout_err), 32'd0);

    // Starvation: both requests held, each re-arms one cycle after its ack
    set_key(8'd0);
    rom_en = 1'b1; rom_lat = 0; rom_byte = 8'h11;
    n = 0;
    bus.cpu_addr = 16'h0010; bus.aux_addr = 16'h0020;
    bus.cpu_req = 1'b1; bus.aux_req = 1'b1;
    for (int i = 0; i < 300 && n < 10; i++) begin
      @(negedge clk_sys);
      if (!bus.cpu_req) bus.cpu_req = 1'b1;
      else if (bus.cpu_ack) begin ord[n] = 0; n++; bus.cpu_req = 1'b0; end
      if (n < 10) begin
        if (!bus.aux_req) bus.aux_req = 1'b1;
        else if (bus.aux_ack) begin ord[n] = 1; n++; bus.aux_req = 1'b0; end
      end
    end
    bus.cpu_req = 1'b0; bus.aux_req = 1'b0;
    chk("starve_grant_count", 32'(n), 32'd10);
    for (int i = 0; i < n; i++) begin
      $display("starve grant %0d: %s", i, ord[i] ? "A" : "C");
      chk($sformatf("starve_order%0d", i), 32'(ord[i]), 32'(exp_ord[i]));
    end
    repeat (8) @(negedge clk_sys);

    // Key change while a CPU read is in flight keeps the latched key
    rom_en = 1'b1; rom_lat = 3; rom_byte = 8'h04;
    fork
      do_read(1'b0, 16'h0000, d, lat);
      begin
        repeat (2) @(negedge clk_sys);
        set_key(8'd1);
      end
    join
    $display("midkey read: dout=%h lat=%0d", d, lat);
    chk("midkey_first", 32'(d), 32'h04);
    chk("midkey_first_lat", 32'(lat), 32'd5);
    rom_lat = 0;
    do_read(1'b0, 16'h0000, d, lat);
    $display("midkey next read: dout=%h lat=%0d", d, lat);
    chk("midkey_second", 32'(d), 32'hC1);

    // Held request after ack must not be re-served
    rom_en = 1'b1; rom_lat = 0; rom_byte = 8'h77;
    bus.cpu_addr = 16'h0040; bus.cpu_req = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 20 && ack_seen == 0; i++) begin
      @(negedge clk_sys);
      if (bus.cpu_ack) ack_seen = 1;
    end
    chk("held_first_ack", 32'(ack_seen), 32'd1);
    cs_seen = 0; ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (bus.rom_cs) cs_seen++;
      if (bus.cpu_ack) ack_seen++;
    end
    $display("held req: extra rom_cs cycles=%0d extra acks=%0d", cs_seen, ack_seen);
    chk("held_no_regrant_cs", 32'(cs_seen), 32'd0);
    chk("held_no_second_ack", 32'(ack_seen), 32'd0);
    bus.cpu_req = 1'b0;
    @(negedge clk_sys);

    // Timeout: ROM never answers
    set_key(8'd0);
    rom_en = 1'b0;
    do_read(1'b0, 16'h0300, d, lat);
    $display("timeout read: dout=%h lat=%0d cs_len=%0d err=%0d", d, lat, last_cs_len, bus.timeout_err);
    chk("timeout_dout", 32'(d), 32'hFF);
    chk("timeout_lat", 32'(lat), 32'd9);
    chk("timeout_cs_len", 32'(last_cs_len), 32'd8);
    chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    rom_en = 1'b1; rom_lat = 0; rom_byte = 8'h04;
    do_read(1'b0, 16'h0000, d, lat);
    chk("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset asserted while the CPU read is outstanding
    rom_en = 1'b0;
    set_key(8'd1);
    bus.cpu_addr = 16'h0500; bus.cpu_req = 1'b1;
    @(negedge clk_sys);
    chk("abort_cs_before_reset", 32'(bus.rom_cs), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    $display("reset abort: rom_cs=%0d ack=%0d dout=%h err=%0d", bus.rom_cs, bus.cpu_ack, bus.cpu_dout, bus.timeout_err);
    chk("abort_rom_cs", 32'(bus.rom_cs), 32'd0);
    chk("abort_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("abort_cpu_dout", 32'(bus.cpu_dout), 32'h00);
    chk("abort_timeout_err", 32'(bus.timeout_err), 32'd0);
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.cpu_ack) ack_seen++;
      @(negedge clk_sys);
    end
    bus.cpu_req = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      if (bus.cpu_ack) ack_seen++;
    end
    chk("abort_no_ack", 32'(ack_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
